// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared mode encodings and index helpers for the FFT reorder path
package fft_pkg;

    typedef enum logic [1:0] {
        MODE_ID  = 2'd0,
        MODE_EO  = 2'd1,
        MODE_BR  = 2'd2,
        MODE_RSV = 2'd3
    } fft_mode_e;

    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < width; b++) begin
            r = (r << 1) | ((idx >> b) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_index_permute.sv
// rtl/fft_index_permute.sv - combinational per-lane index permutation of one frame
module fft_index_permute
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_POINTS   = 32
) (
    input  logic [1:0]                     mode,
    input  logic [N_POINTS*DATA_WIDTH-1:0] in_real,
    input  logic [N_POINTS*DATA_WIDTH-1:0] in_imag,
    output logic [N_POINTS*DATA_WIDTH-1:0] out_real,
    output logic [N_POINTS*DATA_WIDTH-1:0] out_imag
);

    localparam int LOG2_N = $clog2(N_POINTS);
    localparam int HALF   = N_POINTS / 2;

    logic sel_eo;
    logic sel_br;

    assign sel_eo = (mode == MODE_EO);
    assign sel_br = (mode == MODE_BR);

    // Each output lane picks its source lane from constants fixed at elaboration.
    for (genvar i = 0; i < N_POINTS; i++) begin : g_lane
        localparam int EO_SRC = (i < HALF) ? (2 * i) : (2 * (i - HALF) + 1);
        localparam int BR_SRC = int'(bitrev(i, LOG2_N));

        assign out_real[i*DATA_WIDTH +: DATA_WIDTH] =
            sel_eo ? in_real[EO_SRC*DATA_WIDTH +: DATA_WIDTH] :
            sel_br ? in_real[BR_SRC*DATA_WIDTH +: DATA_WIDTH] :
                     in_real[i*DATA_WIDTH +: DATA_WIDTH];

        assign out_imag[i*DATA_WIDTH +: DATA_WIDTH] =
            sel_eo ? in_imag[EO_SRC*DATA_WIDTH +: DATA_WIDTH] :
            sel_br ? in_imag[BR_SRC*DATA_WIDTH +: DATA_WIDTH] :
                     in_imag[i*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

// File: rtl/fft_reorder_buffer.sv
// rtl/fft_reorder_buffer.sv - two-entry ping-pong frame store with write-side permutation
module fft_reorder_buffer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_POINTS   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_mode,
    input  logic [N_POINTS*DATA_WIDTH-1:0] in_real,
    input  logic [N_POINTS*DATA_WIDTH-1:0] in_imag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_POINTS*DATA_WIDTH-1:0] out_real,
    output logic [N_POINTS*DATA_WIDTH-1:0] out_imag,
    output logic [1:0]                     out_mode,
    output logic                           mode_err
);

    localparam int FW = N_POINTS * DATA_WIDTH;

    logic [FW-1:0] perm_real;
    logic [FW-1:0] perm_imag;

    logic [FW-1:0] real_q [2];
    logic [FW-1:0] real_d [2];
    logic [FW-1:0] imag_q [2];
    logic [FW-1:0] imag_d [2];
    logic [1:0]    mode_q [2];
    logic [1:0]    mode_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          mode_err_q, mode_err_d;
    logic          push, pop;

    fft_index_permute #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_POINTS   (N_POINTS)
    ) u_permute (
        .mode     (in_mode),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .out_real (perm_real),
        .out_imag (perm_imag)
    );

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_real  = real_q[rd_ptr_q];
    assign out_imag  = imag_q[rd_ptr_q];
    assign out_mode  = mode_q[rd_ptr_q];
    assign mode_err  = mode_err_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        real_d     = real_q;
        imag_d     = imag_q;
        mode_d     = mode_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mode_err_d = mode_err_q;

        if (push) begin
            real_d[wr_ptr_q] = perm_real;
            imag_d[wr_ptr_q] = perm_imag;
            mode_d[wr_ptr_q] = in_mode;
            wr_ptr_d         = ~wr_ptr_q;
            if (in_mode == MODE_RSV) begin
                mode_err_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Push and pop together leave occupancy unchanged.
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            real_q     <= '{default: '0};
            imag_q     <= '{default: '0};
            mode_q     <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            mode_err_q <= 1'b0;
        end else begin
            real_q     <= real_d;
            imag_q     <= imag_d;
            mode_q     <= mode_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mode_err_q <= mode_err_d;
        end
    end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// tb/tb_fft_reorder_buffer.sv - directed self-checking bench for fft_reorder_buffer
module tb_fft_reorder_buffer;

    localparam int DW = 8;
    localparam int N  = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_mode;
    logic [N*DW-1:0] in_real;
    logic [N*DW-1:0] in_imag;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_real;
    logic [N*DW-1:0] out_imag;
    logic [1:0]      out_mode;
    logic            mode_err;

    int checks;
    int errors;

    fft_reorder_buffer #(
        .DATA_WIDTH (DW),
        .N_POINTS   (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_mode  (out_mode),
        .mode_err  (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample k: real = k + off, imag = 0xFF - k.
    task automatic set_frame(input int off, input logic [1:0] mode);
        for (int k = 0; k < N; k++) begin
            in_real[k*DW +: DW] = 8'(k + off);
            in_imag[k*DW +: DW] = 8'(8'hFF - k);
        end
        in_mode = mode;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] oreal(input int i);
        return out_real[i*DW +: DW];
    endfunction

    function automatic logic [7:0] oimag(input int i);
        return out_imag[i*DW +: DW];
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_frame(0, 2'd0);

        // 1: reset and idle
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_real_zero", 32'(|out_real), 32'd0);
        check("rst_mode_err", 32'(mode_err), 32'd0);

        // 2: even/odd split
        set_frame(0, 2'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("eo_out_valid", 32'(out_valid), 32'd1);
        check("eo_real1", 32'(oreal(1)), 32'd2);
        check("eo_real16", 32'(oreal(16)), 32'd1);
        check("eo_real31", 32'(oreal(31)), 32'd31);
        check("eo_imag16", 32'(oimag(16)), 32'hFE);
        check("eo_mode", 32'(out_mode), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("eo_drained", 32'(out_valid), 32'd0);

        // 3: bit-reverse
        set_frame(0, 2'd2);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("br_real1", 32'(oreal(1)), 32'd16);
        check("br_real3", 32'(oreal(3)), 32'd24);
        check("br_real31", 32'(oreal(31)), 32'd31);
        check("br_imag1", 32'(oimag(1)), 32'hEF);
        check("br_mode", 32'(out_mode), 32'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 4: back-pressure with three back-to-back frames
        set_frame(8'h40, 2'd0);
        in_valid = 1'b1;
        step();
        check("bp_ready_after1", 32'(in_ready), 32'd1);
        check("bp_head_a", 32'(oreal(0)), 32'h40);
        set_frame(8'h60, 2'd0);
        step();
        check("bp_ready_after2", 32'(in_ready), 32'd0);
        check("bp_head_a_stable", 32'(oreal(0)), 32'h40);
        set_frame(8'h80, 2'd0);
        step();
        check("bp_ready_held", 32'(in_ready), 32'd0);
        check("bp_head_a_held", 32'(oreal(5)), 32'h45);
        out_ready = 1'b1;
        step();
        check("bp_head_b", 32'(oreal(0)), 32'h60);
        check("bp_count1_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_head_c", 32'(oreal(0)), 32'h80);
        step();
        out_ready = 1'b0;
        check("bp_empty", 32'(out_valid), 32'd0);

        // 5: streaming at count 1, one frame per cycle
        set_frame(0, 2'd0);
        in_valid = 1'b1;
        step();
        out_ready = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            set_frame(j * 8, 2'd0);
            step();
            check("stream_head", 32'(oreal(0)), 32'(j * 8));
            check("stream_count1", 32'({out_valid, in_ready}), 32'd3);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("stream_drained", 32'(out_valid), 32'd0);

        // 6: reserved mode, sticky error, reset with two frames stored
        set_frame(0, 2'd3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("rsv_mode", 32'(out_mode), 32'd3);
        check("rsv_real5", 32'(oreal(5)), 32'd5);
        check("rsv_imag5", 32'(oimag(5)), 32'hFA);
        check("rsv_err", 32'(mode_err), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check("rsv_err_sticky", 32'(mode_err), 32'd1);
        set_frame(8'h20, 2'd0);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("rst2_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_mode_err", 32'(mode_err), 32'd0);
        check("rst2_real_zero", 32'(|out_real), 32'd0);
        check("rst2_mode_zero", 32'(out_mode), 32'd0);
        out_ready = 1'b1;
        step();
        check("rst2_no_emit", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
